// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: walks the active elements of one strided, masked
// vector load/store and issues them one at a time to the data cache port,
// gathering load results into a packed vector register image.

`ifndef ONE_BYTE
`define ONE_BYTE 3'b000
`endif
`ifndef TWO_BYTE
`define TWO_BYTE 3'b001
`endif
`ifndef FOUR_BYTE
`define FOUR_BYTE 3'b010
`endif
`ifndef EIGHT_BYTE
`define EIGHT_BYTE 3'b011
`endif
`ifndef D_CACHE_NOP
`define D_CACHE_NOP 2'b00
`endif
`ifndef D_CACHE_LOAD
`define D_CACHE_LOAD 2'b01
`endif
`ifndef D_CACHE_STORE
`define D_CACHE_STORE 2'b10
`endif
`ifndef D_CACHE_RESTING
`define D_CACHE_RESTING 2'b00
`endif
`ifndef D_CACHE_WORKING
`define D_CACHE_WORKING 2'b01
`endif
`ifndef D_CACHE_STALL
`define D_CACHE_STALL 2'b10
`endif
`ifndef L_S_FINISHED
`define L_S_FINISHED 2'b11
`endif

module vector_mem_sequencer #(
  parameter int ADDR_WIDTH       = 17,
  parameter int DATA_LEN         = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            vm_start,
  input  logic                            vm_is_store,
  input  logic [ADDR_WIDTH-1:0]           vm_base_addr,
  input  logic [ADDR_WIDTH-1:0]           vm_stride,
  input  logic [2:0]                      vm_vsew,
  input  logic [ENTRY_INDEX_SIZE:0]       vm_vl,
  input  logic [VECTOR_SIZE-1:0]          vm_mask,
  input  logic [DATA_LEN*VECTOR_SIZE-1:0] vm_store_data,
  output logic                            vm_busy,
  output logic                            vm_done,
  output logic                            vm_error,
  output logic [DATA_LEN*VECTOR_SIZE-1:0] vm_load_data,
  output logic [ADDR_WIDTH-1:0]           data_addr,
  output logic [2:0]                      data_type,
  output logic [DATA_LEN-1:0]             cache_written_data,
  output logic [1:0]                      cache_vis_signal,
  output logic [ENTRY_INDEX_SIZE:0]       length,
  input  logic [DATA_LEN-1:0]             data,
  input  logic [1:0]                      d_cache_vis_status
);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_REQ, S_WAIT, S_DONE, S_ERR} state_t;

  state_t                          state, state_nxt;
  logic                            is_store_q;
  logic signed [ADDR_WIDTH-1:0]    stride_q;
  logic signed [ADDR_WIDTH-1:0]    acc_q;
  logic [2:0]                      vsew_q;
  logic [ENTRY_INDEX_SIZE:0]       vl_q;
  logic [ENTRY_INDEX_SIZE:0]       idx_q;
  logic [VECTOR_SIZE-1:0]          mask_q;
  logic [DATA_LEN*VECTOR_SIZE-1:0] store_data_q;
  logic [ENTRY_INDEX_SIZE-1:0]     slot;
  logic                            at_end;
  logic                            elem_active;

  function automatic logic sew_ok(input logic [2:0] s);
    return (s == `ONE_BYTE) || (s == `TWO_BYTE) || (s == `FOUR_BYTE);
  endfunction

  // Keep the low SEW bits of the cache word and clear everything above them.
  function automatic logic [DATA_LEN-1:0] zext_elem(input logic [DATA_LEN-1:0] d,
                                                    input logic [2:0] s);
    logic [DATA_LEN-1:0] r;
    r = '0;
    case (s)
      `ONE_BYTE: r[7:0]  = d[7:0];
      `TWO_BYTE: r[15:0] = d[15:0];
      default:   r       = d;
    endcase
    return r;
  endfunction

  assign slot        = idx_q[ENTRY_INDEX_SIZE-1:0];
  assign at_end      = (idx_q == vl_q);
  assign elem_active = mask_q[slot];
  assign vm_done     = (state == S_DONE);
  assign vm_error    = (state == S_ERR);
  assign length      = (ENTRY_INDEX_SIZE+1)'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: one element examined per SCAN cycle, one access in flight
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (vm_start) begin
        if (!sew_ok(vm_vsew))  state_nxt = S_ERR;
        else if (vm_vl == '0)  state_nxt = S_DONE;
        else                   state_nxt = S_SCAN;
      end
      S_SCAN: if (at_end)           state_nxt = S_DONE;
              else if (elem_active) state_nxt = S_REQ;
      S_REQ:  if (d_cache_vis_status == `D_CACHE_RESTING) state_nxt = S_WAIT;
      S_WAIT: if (d_cache_vis_status == `L_S_FINISHED)    state_nxt = S_SCAN;
      S_DONE: state_nxt = S_IDLE;
      S_ERR:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request operands captured at start; they are only read while busy
  always_ff @(posedge clk) begin
    if (state == S_IDLE && vm_start) begin
      is_store_q   <= vm_is_store;
      stride_q     <= vm_stride;
      vsew_q       <= vm_vsew;
      vl_q         <= (vm_vl > (ENTRY_INDEX_SIZE+1)'(VECTOR_SIZE)) ?
                      (ENTRY_INDEX_SIZE+1)'(VECTOR_SIZE) : vm_vl;
      mask_q       <= vm_mask;
      store_data_q <= vm_store_data;
    end
  end

  // Element walk, cache port and result gathering; reset leaves the port idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q              <= '0;
      acc_q              <= '0;
      vm_busy            <= 1'b0;
      vm_load_data       <= '0;
      data_addr          <= '0;
      data_type          <= `ONE_BYTE;
      cache_written_data <= '0;
      cache_vis_signal   <= `D_CACHE_NOP;
    end else begin
      vm_busy <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: if (vm_start) begin
          idx_q        <= '0;
          acc_q        <= vm_base_addr;
          vm_load_data <= '0;
        end
        S_SCAN: if (!at_end) begin
          if (elem_active) begin
            data_addr        <= acc_q;
            data_type        <= vsew_q;
            cache_vis_signal <= is_store_q ? `D_CACHE_STORE : `D_CACHE_LOAD;
            if (is_store_q)
              cache_written_data <= store_data_q[slot*DATA_LEN +: DATA_LEN];
          end else begin
            idx_q <= idx_q + 1'b1;
            acc_q <= acc_q + stride_q;
          end
        end
        S_REQ: if (d_cache_vis_status == `D_CACHE_RESTING)
          cache_vis_signal <= `D_CACHE_NOP;
        S_WAIT: if (d_cache_vis_status == `L_S_FINISHED) begin
          if (!is_store_q)
            vm_load_data[slot*DATA_LEN +: DATA_LEN] <= zext_elem(data, vsew_q);
          idx_q <= idx_q + 1'b1;
          acc_q <= acc_q + stride_q;
        end
        default: ;
      endcase
    end
  end

endmodule
